// File: rtl/uart_tx_irq.sv
// uart_tx_irq: 8N1 UART transmitter with a sticky, level frame-done interrupt.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx_irq #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_W       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx,
   output logic              busy,
   output logic              intr,
   input  logic              intr_ack
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = $clog2(DATA_W + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   function automatic logic even_parity(input logic [DATA_W-1:0] d);
      even_parity = ^d;
   endfunction
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;
`endif

   state_t              state_r, state_s;
   logic [BAUD_W-1:0]   baud_r, baud_s;
   logic [BIT_W-1:0]    bit_r, bit_s;
   logic [DATA_W-1:0]   shift_r, shift_s;
   logic                tx_r, tx_s;
   logic                ready_r, ready_s;
   logic                busy_r, busy_s;
   logic                intr_r, intr_s;
   logic                baud_end_s;
   logic                frame_done_s;
`ifdef UART_TX_PARITY_EN
   logic                parity_r, parity_s;
`endif

   assign tx_ready = ready_r;
   assign tx       = tx_r;
   assign busy     = busy_r;
   assign intr     = intr_r;

   // Next-state and next-output logic; every output is computed one edge ahead.
   always_comb begin
      state_s      = state_r;
      baud_s       = baud_r;
      bit_s        = bit_r;
      shift_s      = shift_r;
      tx_s         = tx_r;
      ready_s      = ready_r;
      busy_s       = busy_r;
      frame_done_s = 1'b0;
      baud_end_s   = (baud_r == BAUD_LAST);
`ifdef UART_TX_PARITY_EN
      parity_s     = parity_r;
`endif
      case (state_r)
         S_IDLE: begin
            if (tx_valid && ready_r) begin
               state_s = S_START;
               shift_s = tx_data;
               tx_s    = 1'b0;
               ready_s = 1'b0;
               busy_s  = 1'b1;
               baud_s  = {BAUD_W{1'b0}};
               bit_s   = {BIT_W{1'b0}};
`ifdef UART_TX_PARITY_EN
               parity_s = even_parity(tx_data);
`endif
            end else begin
               tx_s    = 1'b1;
               ready_s = 1'b1;
               busy_s  = 1'b0;
            end
         end
         S_START: begin
            if (baud_end_s) begin
               state_s = S_DATA;
               baud_s  = {BAUD_W{1'b0}};
               tx_s    = shift_r[0];
            end else begin
               baud_s  = baud_r + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_end_s) begin
               baud_s  = {BAUD_W{1'b0}};
               shift_s = shift_r >> 1'b1;
               bit_s   = bit_r + 1'b1;
               if (bit_r == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_s = S_PARITY;
                  tx_s    = parity_r;
`else
                  state_s = S_STOP;
                  tx_s    = 1'b1;
`endif
               end else begin
                  tx_s    = shift_s[0];
               end
            end else begin
               baud_s  = baud_r + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_end_s) begin
               state_s = S_STOP;
               baud_s  = {BAUD_W{1'b0}};
               tx_s    = 1'b1;
            end else begin
               baud_s  = baud_r + 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (baud_end_s) begin
               state_s      = S_IDLE;
               baud_s       = {BAUD_W{1'b0}};
               bit_s        = {BIT_W{1'b0}};
               tx_s         = 1'b1;
               ready_s      = 1'b1;
               busy_s       = 1'b0;
               frame_done_s = 1'b1;
            end else begin
               baud_s       = baud_r + 1'b1;
            end
         end
         default: begin
            state_s = S_IDLE;
            baud_s  = {BAUD_W{1'b0}};
            bit_s   = {BIT_W{1'b0}};
            tx_s    = 1'b1;
            ready_s = 1'b1;
            busy_s  = 1'b0;
         end
      endcase

      // Completion outranks a simultaneous acknowledge.
      if (frame_done_s) begin
         intr_s = 1'b1;
      end else if (intr_ack) begin
         intr_s = 1'b0;
      end else begin
         intr_s = intr_r;
      end
   end

   // State and output registers with synchronous reset to an idle line.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= S_IDLE;
         baud_r   <= {BAUD_W{1'b0}};
         bit_r    <= {BIT_W{1'b0}};
         shift_r  <= {DATA_W{1'b0}};
         tx_r     <= 1'b1;
         ready_r  <= 1'b1;
         busy_r   <= 1'b0;
         intr_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_r <= 1'b0;
`endif
      end else begin
         state_r  <= state_s;
         baud_r   <= baud_s;
         bit_r    <= bit_s;
         shift_r  <= shift_s;
         tx_r     <= tx_s;
         ready_r  <= ready_s;
         busy_r   <= busy_s;
         intr_r   <= intr_s;
`ifdef UART_TX_PARITY_EN
         parity_r <= parity_s;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_irq.sv
// Self-checking bench for uart_tx_irq: vector table plus a cycle-level line scoreboard.
module tb_uart_tx_irq;

   localparam int C  = 4;
   localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
   localparam int NB = DW + 3;
`else
   localparam int NB = DW + 2;
`endif
   localparam int FRAME = NB * C;
   localparam int NV    = 6;

   logic          clk      = 1'b0;
   logic          reset    = 1'b1;
   logic          tx_valid = 1'b0;
   logic          intr_ack = 1'b0;
   logic [DW-1:0] tx_data  = 8'h00;
   logic          tx_ready, tx, busy, intr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [DW-1:0] data;
      logic [9:0]    bits;   // line values in time order: [0]=start ... [9]=stop
      logic          par;
   } vec_t;

   vec_t vecs [NV];

   logic exp_q[$];
   int   m_cnt  = 0;
   logic m_intr = 1'b0;
   bit   mon_en = 1'b0;

   uart_tx_irq #(.CLKS_PER_BIT(C), .DATA_W(DW)) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx       (tx),
      .busy     (busy),
      .intr     (intr),
      .intr_ack (intr_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input logic [DW-1:0] d);
      for (int j = 0; j < C; j++) exp_q.push_back(1'b0);
      for (int b = 0; b < DW; b++)
         for (int j = 0; j < C; j++) exp_q.push_back(d[b]);
`ifdef UART_TX_PARITY_EN
      for (int j = 0; j < C; j++) exp_q.push_back(^d);
`endif
      for (int j = 0; j < C; j++) exp_q.push_back(1'b1);
   endtask

   // Model updates on the rising edge, comparisons on the falling edge.
   task automatic scoreboard();
      logic e;
      logic done;
      forever begin
         @(posedge clk);
         if (reset) begin
            m_cnt  = 0;
            m_intr = 1'b0;
            exp_q.delete();
         end else begin
            done = (m_cnt == 1);
            if (m_cnt == 0 && tx_valid) begin
               push_frame(tx_data);
               m_cnt = FRAME;
            end else if (m_cnt > 0) begin
               m_cnt--;
            end
            if (done) m_intr = 1'b1;
            else if (intr_ack) m_intr = 1'b0;
         end
         @(negedge clk);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
         if (mon_en) begin
            chk("sb_tx", tx, e);
            chk("sb_ready", tx_ready, m_cnt == 0);
            chk("sb_busy", busy, m_cnt != 0);
            chk("sb_intr", intr, m_intr);
         end
      end
   endtask

   function automatic logic exp_bit(input vec_t v, input int k);
`ifdef UART_TX_PARITY_EN
      if (k == DW + 1) return v.par;
      if (k == DW + 2) return 1'b1;
`endif
      return v.bits[k];
   endfunction

   // Called on a falling edge; returns on the falling edge after the accept edge.
   task automatic send(input logic [DW-1:0] d);
      tx_valid = 1'b1;
      tx_data  = d;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = ~d;
   endtask

   task automatic ack_intr();
      intr_ack = 1'b1;
      @(negedge clk);
      intr_ack = 1'b0;
      chk("ack_clears", intr, 1'b0);
   endtask

   initial begin
      vecs[0] = '{data: 8'hA5, bits: 10'h34A, par: 1'b0};
      vecs[1] = '{data: 8'h3C, bits: 10'h278, par: 1'b0};
      vecs[2] = '{data: 8'h00, bits: 10'h200, par: 1'b0};
      vecs[3] = '{data: 8'hFF, bits: 10'h3FE, par: 1'b0};
      vecs[4] = '{data: 8'h01, bits: 10'h202, par: 1'b1};
      vecs[5] = '{data: 8'h80, bits: 10'h300, par: 1'b1};

      fork
         scoreboard();
      join_none

      // Reset to idle
      @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b1;
      chk("rst_tx", tx, 1'b1);
      chk("rst_ready", tx_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_intr", intr, 1'b0);
      repeat (20) begin
         @(negedge clk);
         chk("idle_tx", tx, 1'b1);
      end

      // Vector table: line value at the first cycle of each bit, then completion timing
      for (int i = 0; i < NV; i++) begin
         send(vecs[i].data);
         for (int k = 0; k < NB; k++) begin
            chk("vec_bit", tx, exp_bit(vecs[i], k));
            if (k < NB - 1) repeat (C) @(negedge clk);
         end
         repeat (C - 1) @(negedge clk);
         chk("vec_ready_late", tx_ready, 1'b0);
         chk("vec_busy_late", busy, 1'b1);
         @(negedge clk);
         chk("vec_ready_on_time", tx_ready, 1'b1);
         chk("vec_busy_done", busy, 1'b0);
         chk("vec_intr_set", intr, 1'b1);
         ack_intr();
      end

      // Interrupt is sticky until acknowledged
      send(8'hA5);
      repeat (FRAME) @(negedge clk);
      repeat (10) begin
         @(negedge clk);
         chk("intr_hold", intr, 1'b1);
      end
      ack_intr();

      // Ack on the completion edge loses to the set
      send(8'h3C);
      repeat (FRAME - 1) @(negedge clk);
      chk("pre_done_intr", intr, 1'b0);
      intr_ack = 1'b1;
      @(negedge clk);
      intr_ack = 1'b0;
      chk("set_wins", intr, 1'b1);
      @(negedge clk);
      chk("set_wins_hold", intr, 1'b1);
      ack_intr();

      // Busy rejection and capture
      send(8'h3C);
      repeat (10) @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (FRAME - 11) @(negedge clk);
      chk("rej_ready", tx_ready, 1'b1);
      chk("rej_intr", intr, 1'b1);
      repeat (2 * FRAME) @(negedge clk);
      chk("rej_no_frame_tx", tx, 1'b1);
      chk("rej_no_frame_busy", busy, 1'b0);
      ack_intr();

      // Back-to-back with tx_valid held high
      tx_valid = 1'b1;
      tx_data  = 8'h00;
      @(negedge clk);
      tx_data  = 8'hFF;
      repeat (FRAME) @(negedge clk);
      chk("b2b_intr1", intr, 1'b1);
      chk("b2b_ready1", tx_ready, 1'b1);
      intr_ack = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      intr_ack = 1'b0;
      chk("b2b_start2", tx, 1'b0);
      chk("b2b_busy2", busy, 1'b1);
      chk("b2b_intr_acked", intr, 1'b0);
      repeat (FRAME) @(negedge clk);
      chk("b2b_intr2", intr, 1'b1);
      chk("b2b_ready2", tx_ready, 1'b1);

      // Reset during data bit 3 of 0x55 with intr still pending
      send(8'h55);
      repeat (4 * C + 1) @(negedge clk);
      chk("mid_busy", busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mrst_tx", tx, 1'b1);
      chk("mrst_ready", tx_ready, 1'b1);
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_intr", intr, 1'b0);
      repeat (3 * FRAME) @(negedge clk);
      chk("mrst_quiet_tx", tx, 1'b1);
      chk("mrst_quiet_intr", intr, 1'b0);

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
